// File: rtl/abc_vector_sequencer_if.sv
// Stimulus/response bundle between the vector sequencer and the 3-in/2-out circuit under test.
// The sequencer owns the slave side; the harness or circuit wrapper owns the master side.
interface abc_vector_sequencer_if;
  logic        start;
  logic        Y1;
  logic        Y2;
  logic        A;
  logic        B;
  logic        C;
  logic [2:0]  step;
  logic        busy;
  logic        done;
  logic [15:0] result;

  modport slave (
    input  start, Y1, Y2,
    output A, B, C, step, busy, done, result
  );

  modport master (
    output start, Y1, Y2,
    input  A, B, C, step, busy, done, result
  );
endinterface

// File: rtl/abc_vector_sequencer.sv
// Walks {A,B,C} through codes 0..7, holding each for a programmable dwell, and packs the
// {Y1,Y2} response sampled on the last cycle of every hold into a 16-bit result word.
module abc_vector_sequencer #(
  parameter int                   DWELL_W       = 4,
  parameter logic [4*DWELL_W-1:0] DWELL_PATTERN = 16'h4927
) (
  input  logic                  clk,
  input  logic                  rst,
  abc_vector_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  // A zero field still has to present the code for one cycle so it gets captured.
  function automatic logic [DWELL_W-1:0] dwell_of(input logic [1:0] k);
    logic [DWELL_W-1:0] f;
    f = DWELL_PATTERN[int'(k)*DWELL_W +: DWELL_W];
    return (f == '0) ? CNT_ONE : f;
  endfunction

  logic [1:0]         state_q,  state_d;
  logic [2:0]         step_q,   step_d;
  logic [DWELL_W-1:0] cnt_q,    cnt_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [15:0]        result_q, result_d;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          step_d   = 3'd0;
          cnt_d    = dwell_of(2'd0);
          busy_d   = 1'b1;
          result_d = 16'h0000;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Last cycle of the hold: Y1/Y2 are the settled response to the current code.
          result_d[{step_q, 1'b0} +: 2] = {bus.Y1, bus.Y2};
          if (step_q != 3'd7) begin
            step_d = step_q + 3'd1;
            cnt_d  = dwell_of(step_q[1:0] + 2'd1);
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            step_d  = 3'd0;
            cnt_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= 3'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // step is forced back to 0 whenever the sequencer leaves DRIVE, so the code lines
  // can follow it directly and read 000 when idle.
  assign bus.A      = step_q[2];
  assign bus.B      = step_q[1];
  assign bus.C      = step_q[0];
  assign bus.step   = step_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/abc_vector_sequencer.md
Name: abc_vector_sequencer

Overview:
- Synthesizable upstream stimulus stage for the 3-input/2-output logic circuit under test (inputs A, B, C; outputs Y1, Y2).
- Steps A,B,C through all 8 codes 000..111, holding each code for a programmable number of clock cycles.
- Captures {Y1,Y2} on the last cycle of each hold and packs the 8 captures into a 16-bit result word.
- Replaces hand-written delay stimulus; enables on-board (FPGA) checking of the circuit.

Parameters:
- DWELL_W, 4, width of each dwell field and of the internal dwell counter.
- DWELL_PATTERN, 16'h4927, four packed DWELL_W-bit dwell counts. Field k = bits [4k+3:4k] is the dwell for step i where i mod 4 = k. Default dwells are 7, 2, 9, 4. A field value of 0 is treated as 1.

Ports:
- clk     input   1   single clock, rising edge.
- rst     input   1   synchronous, active-high reset.
- start   input   1   level or pulse; sampled only in IDLE.
- Y1      input   1   circuit output 1 (combinational response to A,B,C).
- Y2      input   1   circuit output 2.
- A       output  1   stimulus MSB (step index bit 2).
- B       output  1   stimulus bit 1.
- C       output  1   stimulus LSB (step index bit 0).
- step    output  3   current step index i; {A,B,C} == step while busy.
- busy    output  1   high while vectors are being driven.
- done    output  1   one-cycle pulse after the final capture.
- result  output  16  capture word; bits [2i+1:2i] = {Y1,Y2} sampled for step i.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values, applied at the first rising edge with rst=1, including mid-run:
  - state = IDLE
  - A = B = C = 0, step = 0
  - busy = 0, done = 0, result = 16'h0000, dwell counter = 0
  - No partial result is retained.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs hold at 000 with busy = 0.
  - Edge with start = 1: step <= 0, counter <= dwell(0), busy <= 1, result <= 0, state <= DRIVE.
- DRIVE:
  - Each edge with counter > 1: counter decrements; {A,B,C} holds.
  - Edge with counter == 1 (last cycle of the dwell): result[2*step+1 : 2*step] <= {Y1,Y2}.
  - On that same edge, if step < 7: step <= step + 1, counter <= dwell(step+1).
  - On that same edge, if step == 7: state <= DONE, busy <= 0, done <= 1, {A,B,C} <= 000, step <= 0.
  - Each code i is held for exactly dwell(i) cycles (effective dwell = max(field, 1)).
  - busy is high for exactly the sum of effective dwells. Default: 2*(7+2+9+4) = 44 cycles.
- DONE:
  - Lasts exactly one cycle with done = 1, then IDLE with done <= 0.
  - start is ignored in DONE; a new run begins at the next IDLE edge with start = 1.
- result changes only during DRIVE captures and on the start edge. It holds after done until the next start or reset.
- start asserted during DRIVE or DONE is ignored and does not restart the run.
- Y1/Y2 are sampled in the same cycle as the code that produced them; this stage adds no pipelining.
- rst and start asserted together: reset wins.
- Wrap-around: step never exceeds 7. The pattern index uses step[1:0].

Test Plan:
- Reset check: rst high 2 cycles, then low with start=0 → A,B,C=000, busy=0, done=0, result=16'h0000 held for 20 cycles.
- Default run, bench model Y1=A&B, Y2=B^C; pulse start one cycle → vector 000 held 7 cycles, then 001 held 2, 010 held 9, 011 held 4, then the pattern repeats for 100..111.
  - Required: busy high exactly 44 cycles, done pulses exactly once, result=16'hB414.
- Ignored start: same run with start held high throughout → single 44-cycle run, then an immediate second run after DONE. The second run again gives 16'hB414, and result reads 0 during its first capture window.
- Mid-run reset: assert rst for 1 cycle during step 5 → next cycle A,B,C=000, busy=0, result=0, done stays 0. A new start completes normally.
- Zero dwell: DWELL_PATTERN=16'h0000 → each vector held 1 cycle, busy high exactly 8 cycles, result still 16'hB414.
- Capture timing: Y2 model forced to 1 only on the final cycle of step 2's dwell → result[4]=1 at done. Forcing it only on the first cycle of step 2 (dwell 9) → result[4]=0.
